sdo_resp_checker: RTL and testbench
===================================

# sdo_resp_checker

Synthesizable SDO request/response matcher that consumes the 76-bit frames produced by the MOPSHUB setup generator. It queues every downlink request (`{canid, data}`), pairs each uplink response with the oldest outstanding request, and classifies it as match, mismatch, abort or timeout. Results appear as single-cycle pulses and saturating counters, so the testbench top and on-chip self-test can report pass/fail without software.

## Interface
- `DEPTH`, 4, number of outstanding requests; power of two, 2–16.
- `TIMEOUT_CYC`, 4096, cycles a head request may wait for its response; ≥2.
- `CNT_W`, 16, width of the result counters.

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req_valid` in 1: request frame strobe, one frame per cycle.
- `req_data` in 76: `[75:64]` CAN ID (bits `[74:64]` used), `[63:56]` SDO command byte, `[55:32]` index/subindex, `[31:0]` payload.
- `resp_valid` in 1: response frame strobe.
- `resp_data` in 76: same field layout as `req_data`.
- `match_o` out 1: pulse, response accepted.
- `mismatch_o` out 1: pulse, response wrong.
- `abort_o` out 1: pulse, response command `0x80`. Also counted as a mismatch.
- `timeout_o` out 1: pulse, head request expired.
- `unexpected_o` out 1: pulse, response arrived while the queue was empty.
- `overflow_o` out 1: sticky; a request was dropped because the queue was full.
- `pending_o` out clog2(DEPTH)+1: outstanding request count.
- `ok_cnt_o`, `err_cnt_o` out CNT_W: saturating counters. `err_cnt_o` counts mismatch + timeout + unexpected.

## Operation
- **States:** IDLE (queue empty) and WAIT (head outstanding).
  - IDLE→WAIT on push.
  - WAIT→IDLE when a pop empties the queue without a simultaneous push.
- **Push:** `req_valid` and not full stores `req_data`. If full, the frame is dropped and `overflow_o` is set (cleared only by reset).
- **Pop:** occurs on `resp_valid` in WAIT, or on timeout.
- **Compare rules** (response against head). Match requires all of:
  - `resp[74:64] == head[74:64] - 11'h080` (0x600+n → 0x580+n);
  - `resp[55:32] == head[55:32]`;
  - the command class rule holds:
    - head cmd `[7:5]=3'b010` (upload) requires resp cmd `[7:5]=3'b010`;
    - head cmd `[7:5]=3'b001` (download) requires resp cmd `== 8'h60`.
  - Any other head command class is a mismatch.
  - Resp cmd `8'h80` is always a mismatch and also raises `abort_o`.
- **Timeout counter:**
  - Cleared to 0 whenever a new entry becomes head, and held at 0 in IDLE.
  - Increments each cycle in WAIT.
  - At `TIMEOUT_CYC-1` with no `resp_valid` in that cycle: pop and pulse `timeout_o`.
- **Unexpected response:** `resp_valid` in IDLE raises `unexpected_o` and `err_cnt_o`+1, with no pop.
- **Simultaneous events:**
  - Push and pop in the same cycle are both performed. This is allowed when full: pop frees the slot first.
  - A response arriving in the timeout cycle takes precedence over the timeout.
  - A push in IDLE together with `resp_valid` gives unexpected; the new entry is not compared in that cycle.
- **Counters** saturate at all-ones.
- **Reset values:** all pulses 0, `overflow_o`=0, `pending_o`=0, counters 0, state IDLE, queue pointers 0. Reset mid-operation discards all pending entries with no report.

## Timing
- Result pulses are registered and asserted exactly one cycle after the triggering `resp_valid` (or timeout cycle), each for one cycle.
- Counters update in the same cycle as their pulse.
- `pending_o` reflects a push or pop one cycle after `req_valid`/`resp_valid`.
- Back-to-back `resp_valid` on consecutive cycles gives consecutive pops and pulses; no bubble.
- Timeout fires `TIMEOUT_CYC` cycles after the head was established; `timeout_o` is high on the following cycle.

## Structure
- Package `mopshub_chk_pkg` holds:
  - field offsets (`ID_MSB`/`ID_LSB`, `CMD_*`, `IDX_*`);
  - constants `SDO_TX_BASE=11'h600`, `SDO_RX_BASE=11'h580`, `SDO_DL_RESP=8'h60`, `SDO_ABORT=8'h80`;
  - typedef `chk_result_e {RES_MATCH, RES_MISMATCH, RES_ABORT, RES_TIMEOUT, RES_UNEXP}`.
- Sub-module `chk_sync_fifo` (parameterized width/depth, with full/empty/count and same-cycle push/pop) holds requests. Compare logic, timeout counter, FSM and counters live in the top.

## Test plan
- Reset, then push req ID `0x601`, cmd `0x40`, idx `0x100000`; respond with ID `0x581`, cmd `0x43`, same idx → `match_o` one cycle later, `ok_cnt_o`=1, `pending_o`=0.
- Push download req ID `0x605`, cmd `0x23`; respond with cmd `0x60` but ID `0x586` → `mismatch_o`, `err_cnt_o`=1. Respond with cmd `0x80` → `abort_o` and `mismatch_o` together.
- Push one request with `TIMEOUT_CYC=16` and no response → `timeout_o` 16 cycles after the push cycle+1, `pending_o`=0. Repeat with the response on cycle 15 → match, no timeout.
- With `DEPTH=4`, push 5 requests → `overflow_o`=1, `pending_o`=4. Then push and respond in the same cycle while full → `pending_o` stays 4 and the new frame is stored.
- Send `resp_valid` with the queue empty → `unexpected_o`, `err_cnt_o`+1, `pending_o` stays 0.
- Push 3 requests, assert `rst`=0 for one cycle, then respond → `unexpected_o`, all counters 0 beforehand.

Source files
------------

// File: rtl/sdo_resp_checker_pkg.sv
// Shared field layout, SDO constants and result codes
// for the MOPSHUB SDO request/response checker.
package mopshub_chk_pkg;

    localparam int FRAME_W = 76;
    localparam int ID_MSB  = 74;
    localparam int ID_LSB  = 64;
    localparam int CMD_MSB = 63;
    localparam int CMD_LSB = 56;
    localparam int IDX_MSB = 55;
    localparam int IDX_LSB = 32;

    localparam logic [10:0] SDO_TX_BASE = 11'h600;
    localparam logic [10:0] SDO_RX_BASE = 11'h580;
    localparam logic [7:0]  SDO_DL_RESP = 8'h60;
    localparam logic [7:0]  SDO_ABORT   = 8'h80;

    typedef enum logic [2:0] {
        RES_MATCH,
        RES_MISMATCH,
        RES_ABORT,
        RES_TIMEOUT,
        RES_UNEXP
    } chk_result_e;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } chk_state_e;

    function automatic logic [7:0] frame_cmd(
        input logic [FRAME_W-1:0] f
    );
        return f[CMD_MSB:CMD_LSB];
    endfunction

endpackage

// File: rtl/sdo_resp_checker_if.sv
// Request/response frame bundle between the setup
// generator side and the checker.
interface sdo_resp_checker_if;
    import mopshub_chk_pkg::*;

    logic               req_valid;
    logic [FRAME_W-1:0] req_data;
    logic               resp_valid;
    logic [FRAME_W-1:0] resp_data;

    modport master (
        output req_valid,
        output req_data,
        output resp_valid,
        output resp_data
    );

    modport slave (
        input req_valid,
        input req_data,
        input resp_valid,
        input resp_data
    );

endinterface

// File: rtl/sdo_resp_checker_fifo.sv
// Synchronous FIFO with count; push is accepted while
// full when a pop frees the slot in the same cycle.
module chk_sync_fifo #(
    parameter int WIDTH = 76,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sdo_resp_checker.sv
// Pairs SDO responses with the oldest queued request and
// reports match/mismatch/abort/timeout/unexpected.
module sdo_resp_checker
    import mopshub_chk_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    sdo_resp_checker_if.slave      bus,
    output logic                   match_o,
    output logic                   mismatch_o,
    output logic                   abort_o,
    output logic                   timeout_o,
    output logic                   unexpected_o,
    output logic                   overflow_o,
    output logic [$clog2(DEPTH):0] pending_o,
    output logic [CNT_W-1:0]       ok_cnt_o,
    output logic [CNT_W-1:0]       err_cnt_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [10:0] ID_OFS = SDO_TX_BASE - SDO_RX_BASE;

    chk_state_e         state_q, state_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic [FRAME_W-1:0] head;
    logic               full, empty;
    logic               push, pop, tmo_hit;
    logic [7:0]         h_cmd, r_cmd;
    logic               id_ok, idx_ok, cls_ok, is_abort;
    logic               res_vld;
    chk_result_e        res;
    logic               unused_bits;

    chk_sync_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.req_valid),
        .wdata (bus.req_data),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (pending_o)
    );

    assign tmo_hit = (tmr_q == TW'(TIMEOUT_CYC - 1));
    assign pop  = (state_q == S_WAIT) && !empty
               && (bus.resp_valid || tmo_hit);
    assign push = bus.req_valid && (!full || pop);

    assign h_cmd    = frame_cmd(head);
    assign r_cmd    = frame_cmd(bus.resp_data);
    assign id_ok    = bus.resp_data[ID_MSB:ID_LSB]
                   == (head[ID_MSB:ID_LSB] - ID_OFS);
    assign idx_ok   = bus.resp_data[IDX_MSB:IDX_LSB]
                   == head[IDX_MSB:IDX_LSB];
    assign is_abort = (r_cmd == SDO_ABORT);

    // Only upload and download initiations are checkable.
    always_comb begin
        cls_ok = 1'b0;
        unique case (h_cmd[7:5])
            3'b010:  cls_ok = (r_cmd[7:5] == 3'b010);
            3'b001:  cls_ok = (r_cmd == SDO_DL_RESP);
            default: cls_ok = 1'b0;
        endcase
    end

    assign unused_bits = ^{bus.resp_data[75], head[75],
                           bus.resp_data[31:0], head[31:0]};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:
                if (push)
                    state_d = S_WAIT;
            S_WAIT:
                if (pop && !push && pending_o == CW'(1))
                    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tmr_d = '0;
        if (!pop && state_q == S_WAIT)
            tmr_d = tmr_q + TW'(1);
    end

    // A response in the timeout cycle wins over the timeout.
    always_comb begin
        res_vld = 1'b0;
        res     = RES_MATCH;
        if (state_q == S_IDLE) begin
            if (bus.resp_valid) begin
                res_vld = 1'b1;
                res     = RES_UNEXP;
            end
        end else if (bus.resp_valid) begin
            res_vld = 1'b1;
            if (is_abort)
                res = RES_ABORT;
            else if (id_ok && idx_ok && cls_ok)
                res = RES_MATCH;
            else
                res = RES_MISMATCH;
        end else if (tmo_hit) begin
            res_vld = 1'b1;
            res     = RES_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            tmr_q        <= '0;
            match_o      <= 1'b0;
            mismatch_o   <= 1'b0;
            abort_o      <= 1'b0;
            timeout_o    <= 1'b0;
            unexpected_o <= 1'b0;
            overflow_o   <= 1'b0;
            ok_cnt_o     <= '0;
            err_cnt_o    <= '0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            match_o      <= res_vld && res == RES_MATCH;
            mismatch_o   <= res_vld && (res == RES_MISMATCH
                                     || res == RES_ABORT);
            abort_o      <= res_vld && res == RES_ABORT;
            timeout_o    <= res_vld && res == RES_TIMEOUT;
            unexpected_o <= res_vld && res == RES_UNEXP;
            if (bus.req_valid && full && !pop)
                overflow_o <= 1'b1;
            if (res_vld && res == RES_MATCH && ok_cnt_o != '1)
                ok_cnt_o <= ok_cnt_o + CNT_W'(1);
            if (res_vld && res != RES_MATCH && err_cnt_o != '1)
                err_cnt_o <= err_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sdo_resp_checker.sv
// Directed bench for sdo_resp_checker with DEPTH=4 and
// TIMEOUT_CYC=16.
module tb_sdo_resp_checker;
    import mopshub_chk_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic                   match_o, mismatch_o, abort_o;
    logic                   timeout_o, unexpected_o, overflow_o;
    logic [$clog2(DEPTH):0] pending_o;
    logic [CNT_W-1:0]       ok_cnt_o, err_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    sdo_resp_checker_if bus ();

    sdo_resp_checker #(
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TMO),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .match_o      (match_o),
        .mismatch_o   (mismatch_o),
        .abort_o      (abort_o),
        .timeout_o    (timeout_o),
        .unexpected_o (unexpected_o),
        .overflow_o   (overflow_o),
        .pending_o    (pending_o),
        .ok_cnt_o     (ok_cnt_o),
        .err_cnt_o    (err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [75:0] frm(input logic [10:0] id,
                                        input logic [7:0]  cmd,
                                        input logic [23:0] idx);
        return {1'b0, id, cmd, idx, 32'h1234_5678};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [75:0] f);
        bus.req_valid = 1'b1;
        bus.req_data  = f;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic resp(input logic [75:0] f);
        bus.resp_valid = 1'b1;
        bus.resp_data  = f;
        step();
        bus.resp_valid = 1'b0;
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_data   = '0;
        bus.resp_valid = 1'b0;
        bus.resp_data  = '0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("rst_pend", 32'(pending_o), 0);
        chk("rst_ok", 32'(ok_cnt_o), 0);
        chk("rst_err", 32'(err_cnt_o), 0);
        chk("rst_ovf", 32'(overflow_o), 0);
        chk("rst_match", 32'(match_o), 0);

        push(frm(11'h601, 8'h40, 24'h100000));
        chk("up_pend1", 32'(pending_o), 1);
        resp(frm(11'h581, 8'h43, 24'h100000));
        chk("up_match", 32'(match_o), 1);
        chk("up_mis", 32'(mismatch_o), 0);
        chk("up_ok", 32'(ok_cnt_o), 1);
        chk("up_pend0", 32'(pending_o), 0);
        step();
        chk("up_pulse", 32'(match_o), 0);

        push(frm(11'h605, 8'h23, 24'h200100));
        resp(frm(11'h586, 8'h60, 24'h200100));
        chk("dl_mis", 32'(mismatch_o), 1);
        chk("dl_abort0", 32'(abort_o), 0);
        chk("dl_err", 32'(err_cnt_o), 1);
        push(frm(11'h605, 8'h23, 24'h200100));
        resp(frm(11'h585, 8'h80, 24'h200100));
        chk("ab_abort", 32'(abort_o), 1);
        chk("ab_mis", 32'(mismatch_o), 1);
        chk("ab_err", 32'(err_cnt_o), 2);
        chk("ab_ok", 32'(ok_cnt_o), 1);

        push(frm(11'h602, 8'h40, 24'h100800));
        repeat (TMO - 1) step();
        chk("to_early", 32'(timeout_o), 0);
        chk("to_pend1", 32'(pending_o), 1);
        step();
        chk("to_fire", 32'(timeout_o), 1);
        chk("to_pend0", 32'(pending_o), 0);
        chk("to_err", 32'(err_cnt_o), 3);
        step();
        chk("to_pulse", 32'(timeout_o), 0);

        push(frm(11'h602, 8'h40, 24'h100800));
        repeat (TMO - 1) step();
        resp(frm(11'h582, 8'h4f, 24'h100800));
        chk("late_match", 32'(match_o), 1);
        chk("late_noto", 32'(timeout_o), 0);
        chk("late_ok", 32'(ok_cnt_o), 2);
        step();
        chk("late_noto2", 32'(timeout_o), 0);
        chk("late_pend", 32'(pending_o), 0);

        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.req_data = frm(11'h610 + 11'(i), 8'h40, 24'(i));
            step();
        end
        bus.req_valid = 1'b0;
        chk("ovf_pend", 32'(pending_o), 4);
        chk("ovf_flag", 32'(overflow_o), 1);
        bus.req_valid  = 1'b1;
        bus.req_data   = frm(11'h615, 8'h40, 24'h5);
        bus.resp_valid = 1'b1;
        bus.resp_data  = frm(11'h590, 8'h43, 24'h0);
        step();
        bus.req_valid = 1'b0;
        chk("full_match", 32'(match_o), 1);
        chk("full_pend", 32'(pending_o), 4);
        for (int i = 1; i < 5; i++) begin
            bus.resp_data = (i == 4)
                ? frm(11'h595, 8'h43, 24'h5)
                : frm(11'h590 + 11'(i), 8'h43, 24'(i));
            step();
            chk($sformatf("drain%0d", i), 32'(match_o), 1);
        end
        bus.resp_valid = 1'b0;
        chk("drain_ok", 32'(ok_cnt_o), 7);
        chk("drain_pend", 32'(pending_o), 0);
        chk("drain_ovf", 32'(overflow_o), 1);

        resp(frm(11'h581, 8'h43, 24'h100000));
        chk("ux_flag", 32'(unexpected_o), 1);
        chk("ux_err", 32'(err_cnt_o), 4);
        chk("ux_pend", 32'(pending_o), 0);
        chk("ux_match", 32'(match_o), 0);

        bus.req_valid  = 1'b1;
        bus.req_data   = frm(11'h603, 8'h40, 24'h101800);
        bus.resp_valid = 1'b1;
        bus.resp_data  = frm(11'h583, 8'h43, 24'h101800);
        step();
        bus.req_valid  = 1'b0;
        bus.resp_valid = 1'b0;
        chk("pr_unexp", 32'(unexpected_o), 1);
        chk("pr_match", 32'(match_o), 0);
        chk("pr_pend", 32'(pending_o), 1);
        chk("pr_err", 32'(err_cnt_o), 5);
        resp(frm(11'h583, 8'h43, 24'h101800));
        chk("pr_match2", 32'(match_o), 1);
        chk("pr_ok", 32'(ok_cnt_o), 8);

        bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req_data = frm(11'h620 + 11'(i), 8'h40, 24'(i));
            step();
        end
        bus.req_valid = 1'b0;
        chk("mr_pend3", 32'(pending_o), 3);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mr_pend0", 32'(pending_o), 0);
        chk("mr_ok", 32'(ok_cnt_o), 0);
        chk("mr_err", 32'(err_cnt_o), 0);
        chk("mr_ovf", 32'(overflow_o), 0);
        resp(frm(11'h5a0, 8'h43, 24'h0));
        chk("mr_unexp", 32'(unexpected_o), 1);
        chk("mr_err1", 32'(err_cnt_o), 1);
        chk("mr_nomatch", 32'(match_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
